// File: rtl/alu_result_select_pkg.sv
// alu_pkg: shared definitions for the ALU result selector.
//   DATA_W   - operand width; widened results are 2*DATA_W bits
//   OP_*     - opcode encodings for the four functional units
//   entry_t  - one buffered result: {result, opcode, zero, neg}
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef struct packed {
    logic [2*DATA_W-1:0] result;
    logic [1:0]          opcode;
    logic                zero;
    logic                neg;
  } entry_t;

endpackage

// File: rtl/alu_result_select_fifo.sv
// result_fifo: generic DEPTH-entry valid/ready buffer.
//   clk, reset          - clock, synchronous active-high reset
//   wr_valid/wr_ready   - write handshake; push on wr_valid && wr_ready
//   wr_data             - entry to push
//   rd_valid/rd_ready   - read handshake; pop on rd_valid && rd_ready
//   rd_data             - head entry
// wr_ready depends only on the stored count, so there is no combinational
// path from rd_ready back to wr_ready.
module result_fifo #(
  parameter int               WIDTH    = 20,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign wr_ready = (count < CNT_W'(DEPTH));
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  // Storage, pointers and occupancy. DEPTH is a power of two, so the
  // pointers wrap simply by overflowing. The memory is cleared on reset
  // so the head shows the defined reset entry before anything is pushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_DATA;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/alu_result_select.sv
// alu_result_select: registered, handshaked 4:1 ALU result selector.
//   clk, reset            - clock, synchronous active-high reset
//   in_valid/in_ready     - input handshake
//   opcode, sign_ext      - unit select and narrow-result extension mode
//   add/and/xor_answer    - DATA_W-bit unit results
//   mul_answer            - 2*DATA_W-bit multiplier result
//   out_valid/out_ready   - output handshake
//   final_answer, out_opcode, flag_zero, flag_neg - head entry fields
// Entry widths come from alu_pkg, so DATA_W here must match the package.
module alu_result_select
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          opcode,
  input  logic                sign_ext,
  input  logic [DATA_W-1:0]   add_answer,
  input  logic [DATA_W-1:0]   and_answer,
  input  logic [DATA_W-1:0]   xor_answer,
  input  logic [2*DATA_W-1:0] mul_answer,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] final_answer,
  output logic [1:0]          out_opcode,
  output logic                flag_zero,
  output logic                flag_neg
);

  localparam entry_t RST_ENTRY = '{result: '0, opcode: OP_ADD, zero: 1'b1, neg: 1'b0};

  logic [DATA_W-1:0]   narrow;
  logic [2*DATA_W-1:0] widened;
  entry_t              in_entry;
  entry_t              head_entry;

  // Pick the unit result and widen it. Narrow results get their upper half
  // from the sign bit or zeros; the product is already full width. The
  // 2-bit opcode covers all four cases, so nothing can latch.
  always_comb begin
    narrow  = '0;
    widened = '0;
    unique case (opcode)
      OP_ADD: narrow = add_answer;
      OP_AND: narrow = and_answer;
      OP_XOR: narrow = xor_answer;
      OP_MUL: narrow = '0;
    endcase
    if (opcode == OP_MUL) begin
      widened = mul_answer;
    end else if (sign_ext) begin
      widened = {{DATA_W{narrow[DATA_W-1]}}, narrow};
    end else begin
      widened = {{DATA_W{1'b0}}, narrow};
    end
  end

  // Flags travel with the result so the output side needs no logic.
  assign in_entry.result = widened;
  assign in_entry.opcode = opcode;
  assign in_entry.zero   = (widened == '0);
  assign in_entry.neg    = widened[2*DATA_W-1];

  result_fifo #(
    .WIDTH    ($bits(entry_t)),
    .DEPTH    (DEPTH),
    .RST_DATA (RST_ENTRY)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (in_entry),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (head_entry)
  );

  assign final_answer = head_entry.result;
  assign out_opcode   = head_entry.opcode;
  assign flag_zero    = head_entry.zero;
  assign flag_neg     = head_entry.neg;

endmodule

// File: tb/tb_alu_result_select.sv
// tb_alu_result_select: directed vector table, hand-written handshake
// sequences and a randomized run against a queue-based reference model.
module tb_alu_result_select;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          opcode;
  logic                sign_ext;
  logic [DATA_W-1:0]   add_answer;
  logic [DATA_W-1:0]   and_answer;
  logic [DATA_W-1:0]   xor_answer;
  logic [2*DATA_W-1:0] mul_answer;
  logic                out_valid;
  logic                out_ready;
  logic [2*DATA_W-1:0] final_answer;
  logic [1:0]          out_opcode;
  logic                flag_zero;
  logic                flag_neg;

  int vectors_applied = 0;
  int miscompares     = 0;

  typedef struct {
    logic [1:0]  op;
    logic        se;
    logic [7:0]  a_add;
    logic [7:0]  a_and;
    logic [7:0]  a_xor;
    logic [15:0] a_mul;
    logic [15:0] exp_result;
    logic        exp_zero;
    logic        exp_neg;
  } vec_t;

  typedef struct {
    logic [15:0] result;
    logic [1:0]  op;
  } model_t;

  vec_t   vecs[8];
  model_t model_q[$];

  alu_result_select #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .sign_ext     (sign_ext),
    .add_answer   (add_answer),
    .and_answer   (and_answer),
    .xor_answer   (xor_answer),
    .mul_answer   (mul_answer),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .final_answer (final_answer),
    .out_opcode   (out_opcode),
    .flag_zero    (flag_zero),
    .flag_neg     (flag_neg)
  );

  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic se,
                               input logic [7:0] a_add, input logic [7:0] a_and,
                               input logic [7:0] a_xor, input logic [15:0] a_mul,
                               input logic ordy);
    in_valid   = v;
    opcode     = op;
    sign_ext   = se;
    add_answer = a_add;
    and_answer = a_and;
    xor_answer = a_xor;
    mul_answer = a_mul;
    out_ready  = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rule: narrow results are widened arithmetically from their
  // numeric value; the product passes through unchanged.
  function automatic logic [15:0] refResult(input logic [1:0] op, input logic se,
                                            input logic [7:0] a_add, input logic [7:0] a_and,
                                            input logic [7:0] a_xor, input logic [15:0] a_mul);
    int v;
    if (op == 2'd3) return a_mul;
    v = (op == 2'd0) ? int'(a_add) : (op == 2'd1) ? int'(a_and) : int'(a_xor);
    if (se && v >= 128) v = v + 65536 - 256;
    return 16'(v);
  endfunction

  task automatic pushOne(input logic [7:0] val, input logic ordy);
    applyStimulus(1'b1, 2'b00, 1'b0, val, 8'h00, 8'h00, 16'h0000, ordy);
  endtask

  initial begin
    vecs[0] = '{2'b00, 1'b1, 8'hF0, 8'h5A, 8'h3C, 16'h1234, 16'hFFF0, 1'b0, 1'b1};
    vecs[1] = '{2'b10, 1'b0, 8'h11, 8'h22, 8'hF0, 16'h4321, 16'h00F0, 1'b0, 1'b0};
    vecs[2] = '{2'b01, 1'b1, 8'h99, 8'h00, 8'h77, 16'h5555, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{2'b11, 1'b0, 8'hFF, 8'hFF, 8'hFF, 16'h8001, 16'h8001, 1'b0, 1'b1};
    vecs[4] = '{2'b00, 1'b0, 8'h80, 8'h01, 8'h02, 16'h0003, 16'h0080, 1'b0, 1'b0};
    vecs[5] = '{2'b01, 1'b1, 8'hC3, 8'h7F, 8'hE1, 16'hFFFF, 16'h007F, 1'b0, 1'b0};
    vecs[6] = '{2'b10, 1'b1, 8'h05, 8'h06, 8'h80, 16'h0007, 16'hFF80, 1'b0, 1'b1};
    vecs[7] = '{2'b11, 1'b1, 8'hAA, 8'hBB, 8'hCC, 16'h0000, 16'h0000, 1'b1, 1'b0};

    reset = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_final", 32'(final_answer), 32'd0);
    checkOutput("rst_opcode", 32'(out_opcode), 32'd0);
    checkOutput("rst_zero", 32'(flag_zero), 32'd1);
    checkOutput("rst_neg", 32'(flag_neg), 32'd0);

    // Directed select/extend/flag vectors, one-cycle latency each.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].se, vecs[i].a_add, vecs[i].a_and,
                    vecs[i].a_xor, vecs[i].a_mul, 1'b1);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1);
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d_result", i), 32'(final_answer), 32'(vecs[i].exp_result));
      checkOutput($sformatf("vec%0d_opcode", i), 32'(out_opcode), 32'(vecs[i].op));
      checkOutput($sformatf("vec%0d_zero", i), 32'(flag_zero), 32'(vecs[i].exp_zero));
      checkOutput($sformatf("vec%0d_neg", i), 32'(flag_neg), 32'(vecs[i].exp_neg));
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: fill with 1 and 2, hold 3 off while full.
    pushOne(8'd1, 1'b0);
    @(posedge clk); @(negedge clk);
    checkOutput("bp_ready_after1", 32'(in_ready), 32'd1);
    pushOne(8'd2, 1'b0);
    @(posedge clk); @(negedge clk);
    checkOutput("bp_ready_full", 32'(in_ready), 32'd0);
    pushOne(8'd3, 1'b0);
    @(posedge clk); @(negedge clk);
    checkOutput("bp_still_full", 32'(in_ready), 32'd0);
    checkOutput("bp_head_held", 32'(final_answer), 32'd1);
    pushOne(8'd3, 1'b1);
    @(posedge clk); @(negedge clk);
    checkOutput("bp_second", 32'(final_answer), 32'd2);
    checkOutput("bp_ready_back", 32'(in_ready), 32'd1);
    pushOne(8'd3, 1'b1);
    @(posedge clk); @(negedge clk);
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1);
    checkOutput("bp_third_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_third", 32'(final_answer), 32'd3);
    @(posedge clk); @(negedge clk);
    checkOutput("bp_empty", 32'(out_valid), 32'd0);

    // Streaming 10 values at full rate across pointer wrap.
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        checkOutput($sformatf("stream%0d_valid", i - 1), 32'(out_valid), 32'd1);
        checkOutput($sformatf("stream%0d_val", i - 1), 32'(final_answer), 32'(10 + i - 1));
      end
      if (i < 10) pushOne(8'(10 + i), 1'b1);
      else applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1);
      @(posedge clk); @(negedge clk);
    end
    checkOutput("stream_empty", 32'(out_valid), 32'd0);

    // Reset with two entries buffered.
    pushOne(8'h41, 1'b0);
    @(posedge clk); @(negedge clk);
    pushOne(8'h42, 1'b0);
    @(posedge clk); @(negedge clk);
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0);
    checkOutput("mid_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_final", 32'(final_answer), 32'd0);
    checkOutput("mid_rst_zero", 32'(flag_zero), 32'd1);

    // Randomized traffic against the queue model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        v, ordy, se, do_push, do_pop;
      logic [1:0]  op;
      logic [7:0]  a1, a2, a3;
      logic [15:0] m;
      model_t      e;
      checkOutput("rnd_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      checkOutput("rnd_in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
      if (model_q.size() != 0) begin
        checkOutput("rnd_result", 32'(final_answer), 32'(model_q[0].result));
        checkOutput("rnd_opcode", 32'(out_opcode), 32'(model_q[0].op));
        checkOutput("rnd_zero", 32'(flag_zero), 32'(model_q[0].result == 16'd0));
        checkOutput("rnd_neg", 32'(flag_neg), 32'(model_q[0].result >= 16'h8000));
      end
      v    = 1'($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 2) != 0);
      se   = 1'($urandom);
      op   = 2'($urandom);
      a1   = 8'($urandom);
      a2   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      a3   = 8'($urandom);
      m    = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      applyStimulus(v, op, se, a1, a2, a3, m, ordy);
      do_pop  = (model_q.size() != 0) && ordy;
      do_push = v && (model_q.size() < DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.result = refResult(op, se, a1, a2, a3, m);
        e.op     = op;
        model_q.push_back(e);
      end
      @(posedge clk); @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
